// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a shared sample FIFO; locks a producer for BURST_LEN
// consecutive writes so paired samples (L/R, I/Q) stay contiguous in the FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | round-robin search from rr_ptr; a transfer may open a burst
// S_BURST | only `lock` is served until BURST_LEN writes land or it drops valid
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 24,
    parameter int BURST_LEN  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          wr_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          burst_active,
    output logic [CNT_WIDTH-1:0]          abort_count
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [BCNT_W-1:0] BURST_END = BCNT_W'(BURST_LEN);

    logic [0:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  lock;
    logic [BCNT_W-1:0] cnt;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  sel_idle;
    logic [IDX_W-1:0]  cand;
    logic              found;
    logic              transfer;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == LAST_IDX) ? '0 : v + IDX_W'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping; rr_ptr itself when nobody is valid.
    always_comb begin
        sel_idle = rr_ptr;
        cand     = rr_ptr;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                sel_idle = cand;
                found    = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    assign sel          = (state == S_BURST) ? lock : sel_idle;
    // Reset gates the write path combinationally so nothing leaks out while it is held.
    assign transfer     = req_valid[sel] & ~fifo_full & ~reset;
    assign fifo_wr_en   = transfer;
    assign fifo_din     = req_data[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
    assign req_ready    = transfer ? (NUM_REQ'(1) << sel) : '0;
    assign grant_idx    = sel;
    assign burst_active = (state == S_BURST);

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            lock        <= '0;
            cnt         <= '0;
            abort_count <= '0;
        end else if (state == S_IDLE) begin
            if (transfer) begin
                if (BURST_LEN == 1) begin
                    rr_ptr <= wrap_inc(sel);
                end else begin
                    lock  <= sel;
                    cnt   <= BCNT_W'(1);
                    state <= S_BURST;
                end
            end
        end else begin
            if (!req_valid[lock]) begin
                // Locked producer went away: give up the burst and move on.
                rr_ptr <= wrap_inc(lock);
                state  <= S_IDLE;
                if (abort_count != '1) begin
                    abort_count <= abort_count + CNT_WIDTH'(1);
                end
            end else if (transfer) begin
                if (cnt + BCNT_W'(1) == BURST_END) begin
                    rr_ptr <= wrap_inc(lock);
                    state  <= S_IDLE;
                end else begin
                    cnt <= cnt + BCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a behavioural arbitration model, on three parameter sets.
module tb_fifo_wr_arbiter;

    logic wr_clk;
    logic reset;

    // u_a: 2 requesters, bursts of 2, 3-bit abort counter (saturates at 7)
    logic [1:0]  a_valid;
    logic [47:0] a_data;
    logic [1:0]  a_ready;
    logic        a_full;
    logic        a_wr;
    logic [23:0] a_din;
    logic [0:0]  a_gnt;
    logic        a_burst;
    logic [2:0]  a_abort;

    // u_b: 4 requesters, pure round-robin
    logic [3:0]  b_valid;
    logic [31:0] b_data;
    logic [3:0]  b_ready;
    logic        b_full;
    logic        b_wr;
    logic [7:0]  b_din;
    logic [1:0]  b_gnt;
    logic        b_burst;
    logic [3:0]  b_abort;

    // u_c: 2 requesters, pure round-robin
    logic [1:0]  c_valid;
    logic [15:0] c_data;
    logic [1:0]  c_ready;
    logic        c_full;
    logic        c_wr;
    logic [7:0]  c_din;
    logic [0:0]  c_gnt;
    logic        c_burst;
    logic [3:0]  c_abort;

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(24), .BURST_LEN(2), .CNT_WIDTH(3)) u_a (
        .wr_clk(wr_clk), .reset(reset), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .fifo_full(a_full), .fifo_wr_en(a_wr), .fifo_din(a_din),
        .grant_idx(a_gnt), .burst_active(a_burst), .abort_count(a_abort));

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)) u_b (
        .wr_clk(wr_clk), .reset(reset), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .fifo_full(b_full), .fifo_wr_en(b_wr), .fifo_din(b_din),
        .grant_idx(b_gnt), .burst_active(b_burst), .abort_count(b_abort));

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)) u_c (
        .wr_clk(wr_clk), .reset(reset), .req_valid(c_valid), .req_data(c_data),
        .req_ready(c_ready), .fifo_full(c_full), .fifo_wr_en(c_wr), .fifo_din(c_din),
        .grant_idx(c_gnt), .burst_active(c_burst), .abort_count(c_abort));

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got=%h expected=%h", name, got, exp);
        else n_pass++;
    endtask

    // Reference model: owner = -1 means no burst is open.
    typedef struct {
        int rr;
        int owner;
        int written;
        int aborts;
    } mstate_t;

    task automatic model_step(input int n, input int blen, input int amax,
                              input logic [31:0] v, input logic full, inout mstate_t s,
                              output int sel, output logic wr, output logic burst,
                              output int aborts);
        bit hit;
        burst  = (s.owner >= 0);
        aborts = s.aborts;
        if (s.owner >= 0) begin
            sel = s.owner;
        end else begin
            sel = s.rr;
            hit = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (!hit && v[(s.rr + k) % n]) begin
                    sel = (s.rr + k) % n;
                    hit = 1'b1;
                end
            end
        end
        wr = v[sel] && !full;
        if (s.owner >= 0) begin
            if (!v[sel]) begin
                s.rr    = (sel + 1) % n;
                s.owner = -1;
                if (s.aborts < amax) s.aborts++;
            end else if (wr) begin
                s.written++;
                if (s.written == blen) begin
                    s.rr    = (sel + 1) % n;
                    s.owner = -1;
                end
            end
        end else if (wr) begin
            if (blen == 1) s.rr = (sel + 1) % n;
            else begin
                s.owner   = sel;
                s.written = 1;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic        full;
        logic        wr;
        logic        gnt;
        logic        burst;
        logic [2:0]  ab;
        logic [23:0] din;
    } row_t;

    row_t tbl[18];

    task automatic do_reset();
        @(negedge wr_clk);
        reset   = 1'b1;
        a_valid = '0; b_valid = '0; c_valid = '0;
        a_full  = 1'b0; b_full = 1'b0; c_full = 1'b0;
        @(negedge wr_clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt0, cnt1, sel, ab;
        logic wr, burst;
        mstate_t ma, mb;
        logic [1:0] a_acc;
        logic [3:0] b_acc;

        reset   = 1'b1;
        a_valid = '0; a_data = '0; a_full = 1'b0;
        b_valid = '0; b_data = '0; b_full = 1'b0;
        c_valid = '0; c_data = '0; c_full = 1'b0;
        repeat (2) @(negedge wr_clk);
        reset = 1'b0;
        #1;
        check("reset_state", 64'({a_wr, a_ready, a_gnt, a_burst, a_abort}), 64'(0));

        // both valid, then mid-burst full stall, then locked producer drops valid
        tbl[0]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 24'hA00000};
        tbl[1]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 24'hA00001};
        tbl[2]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 24'hB00000};
        tbl[3]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 24'hB00001};
        tbl[4]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 24'hA00002};
        tbl[5]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 24'hA00003};
        tbl[6]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 24'hB00002};
        tbl[7]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 24'hB00003};
        tbl[8]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 24'hA00004};
        for (int i = 9; i < 14; i++) tbl[i] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 24'h0};
        tbl[14] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 24'hA00005};
        tbl[15] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 24'hB00004};
        tbl[16] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 24'h0};
        tbl[17] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 24'hA00006};

        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge wr_clk);
            a_valid = tbl[i].rv;
            a_full  = tbl[i].full;
            a_data  = {24'hB00000 + 24'(cnt1), 24'hA00000 + 24'(cnt0)};
            #1;
            check($sformatf("vec%0d", i),
                  64'({a_wr, a_gnt, a_ready, a_burst, a_abort, (tbl[i].wr ? a_din : 24'h0)}),
                  64'({tbl[i].wr, tbl[i].gnt,
                       (tbl[i].wr ? (tbl[i].gnt ? 2'b10 : 2'b01) : 2'b00),
                       tbl[i].burst, tbl[i].ab, tbl[i].din}));
            if (tbl[i].wr) begin
                if (tbl[i].gnt) cnt1++;
                else cnt0++;
            end
        end

        // asynchronous reset in the middle of a burst
        @(posedge wr_clk);
        #3;
        a_data = {24'hB00000 + 24'(cnt1), 24'hA00000 + 24'(cnt0)};
        #1;
        check("rst_pre", 64'({a_burst, a_wr, a_din}), 64'({1'b1, 1'b1, 24'hA00007}));
        reset = 1'b1;
        #1;
        check("rst_immediate", 64'({a_wr, a_ready, a_burst, a_abort}), 64'(0));
        @(posedge wr_clk);
        #2;
        check("rst_held", 64'({a_wr, a_ready}), 64'(0));
        reset = 1'b0;
        #1;
        check("rst_after", 64'({a_wr, a_gnt, a_ready, a_burst, a_abort, a_din}),
              64'({1'b1, 1'b0, 2'b01, 1'b0, 3'd0, 24'hA00007}));
        @(negedge wr_clk);
        a_valid = '0;

        // single active requester, pure round-robin
        for (int k = 0; k < 6; k++) begin
            @(negedge wr_clk);
            c_valid = 2'b10;
            c_data  = {8'h10 + 8'(k), 8'h00};
            #1;
            check($sformatf("solo%0d", k), 64'({c_wr, c_gnt, c_ready, c_burst, c_din}),
                  64'({1'b1, 1'b1, 2'b10, 1'b0, 8'h10 + 8'(k)}));
        end
        @(negedge wr_clk);
        c_valid = '0;

        // four requesters, only 0 and 2 valid
        for (int k = 0; k < 8; k++) begin
            @(negedge wr_clk);
            b_valid = 4'b0101;
            b_data  = {8'h43, 8'h42, 8'h41, 8'h40};
            #1;
            check($sformatf("alt%0d", k), 64'({b_wr, b_gnt, b_ready, b_din}),
                  64'({1'b1, 2'(2 * (k % 2)), 4'(1 << (2 * (k % 2))), 8'(8'h40 + 2 * (k % 2))}));
        end

        // randomized traffic on u_a and u_b in parallel
        do_reset();
        ma = '{0, -1, 0, 0};
        mb = '{0, -1, 0, 0};
        a_acc = '0;
        b_acc = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge wr_clk);
            for (int i = 0; i < 2; i++) begin
                if (a_valid[i] && !a_acc[i]) begin
                    if ($urandom_range(0, 99) < 12) a_valid[i] = 1'b0;
                end else begin
                    a_valid[i] = ($urandom_range(0, 99) < 65);
                    a_data[i*24 +: 24] = 24'($urandom);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (b_valid[i] && !b_acc[i]) begin
                    if ($urandom_range(0, 99) < 10) b_valid[i] = 1'b0;
                end else begin
                    b_valid[i] = ($urandom_range(0, 99) < 50);
                    b_data[i*8 +: 8] = 8'($urandom);
                end
            end
            a_full = ($urandom_range(0, 99) < 25);
            b_full = ($urandom_range(0, 99) < 20);
            #1;
            model_step(2, 2, 7, 32'(a_valid), a_full, ma, sel, wr, burst, ab);
            check("rand_a", 64'({a_wr, a_gnt, a_ready, a_burst, a_abort, (wr ? a_din : 24'h0)}),
                  64'({wr, 1'(sel), (wr ? 2'(1 << sel) : 2'b00), burst, 3'(ab),
                       (wr ? a_data[sel*24 +: 24] : 24'h0)}));
            a_acc = wr ? 2'(1 << sel) : 2'b00;
            model_step(4, 1, 15, 32'(b_valid), b_full, mb, sel, wr, burst, ab);
            check("rand_b", 64'({b_wr, b_gnt, b_ready, b_burst, b_abort, (wr ? b_din : 8'h0)}),
                  64'({wr, 2'(sel), (wr ? 4'(1 << sel) : 4'b0000), burst, 4'(ab),
                       (wr ? b_data[sel*8 +: 8] : 8'h0)}));
            b_acc = wr ? 4'(1 << sel) : 4'b0000;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
